// File: rtl/inst_cache_pkg.sv
// Shared types and address-field width helpers for the direct-mapped instruction cache.
package inst_cache_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOOKUP    = 3'd1,
    FILL_REQ  = 3'd2,
    FILL_WAIT = 3'd3,
    FILL_NEXT = 3'd4,
    DONE      = 3'd5
  } state_t;

  function automatic int offset_width(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int index_width(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int tag_width(input int addr_size, input int line_words, input int depth);
    return addr_size - 2 - $clog2(line_words) - $clog2(depth);
  endfunction

endpackage

// File: rtl/instruction_cache_array.sv
// Line storage: word-writable data array with whole-line combinational read, plus tag/valid state.
module instruction_cache_array
  import inst_cache_pkg::*;
#(
  parameter int ADDR_SIZE  = 32,
  parameter int LINE_WORDS = 4,
  parameter int DEPTH      = 16
) (
  input  logic                                               clock,
  input  logic                                               reset,
  input  logic                                               flush,
  input  logic                                               invalidate,
  input  logic [index_width(DEPTH)-1:0]                      index,
  input  logic [offset_width(LINE_WORDS)-1:0]                word,
  input  logic [31:0]                                        wdata,
  input  logic                                               we,
  input  logic                                               tag_we,
  input  logic [tag_width(ADDR_SIZE, LINE_WORDS, DEPTH)-1:0] tag_in,
  output logic [LINE_WORDS*32-1:0]                           line,
  output logic [tag_width(ADDR_SIZE, LINE_WORDS, DEPTH)-1:0] line_tag,
  output logic                                               line_valid
);

  localparam int TAG_W = tag_width(ADDR_SIZE, LINE_WORDS, DEPTH);

  logic [31:0]      mem [DEPTH][LINE_WORDS];
  logic [TAG_W-1:0] tags [DEPTH];
  logic [DEPTH-1:0] valid;

  always_ff @(posedge clock) begin
    if (we) mem[index][word] <= wdata;
  end

  always_ff @(posedge clock) begin
    if (tag_we) tags[index] <= tag_in;
  end

  // Flush beats everything; invalidate marks a line as mid-fill so it cannot hit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid <= '0;
    end else if (flush) begin
      valid <= '0;
    end else if (invalidate) begin
      valid[index] <= 1'b0;
    end else if (tag_we) begin
      valid[index] <= 1'b1;
    end
  end

  always_comb begin
    line = '0;
    for (int w = 0; w < LINE_WORDS; w++) begin
      line[w*32 +: 32] = mem[index][w];
    end
  end

  assign line_tag   = tags[index];
  assign line_valid = valid[index];

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache between the memory controller and the instruction ROM.
module instruction_cache
  import inst_cache_pkg::*;
#(
  parameter int ADDR_SIZE  = 32,
  parameter int LINE_WORDS = 4,
  parameter int DEPTH      = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 inst_cache_enable,
  input  logic [ADDR_SIZE-1:0] inst_cache_addr,
  input  logic                 inst_cache_flush,
  output logic [31:0]          inst_cache_data,
  output logic                 inst_cache_busy,
  output logic                 rom_enable,
  output logic [ADDR_SIZE-1:0] rom_addr,
  input  logic [31:0]          rom_data,
  input  logic                 rom_busy
);

  localparam int OFF_W = offset_width(LINE_WORDS);
  localparam int IDX_W = index_width(DEPTH);
  localparam int TAG_W = tag_width(ADDR_SIZE, LINE_WORDS, DEPTH);

  state_t               state;
  logic [ADDR_SIZE-1:0] req_addr;
  logic [OFF_W-1:0]     count;
  logic                 flush_pending;

  logic [TAG_W-1:0]        req_tag;
  logic [IDX_W-1:0]        req_index;
  logic [OFF_W-1:0]        req_off;
  logic [LINE_WORDS*32-1:0] line;
  logic [TAG_W-1:0]        line_tag;
  logic                    line_valid;
  logic                    hit;
  logic [31:0]             hit_word;
  logic                    fill_we;
  logic                    fill_last;
  logic                    tag_we;
  logic                    invalidate;
  logic                    flush_now;
  logic                    byte_bits_unused;

  assign req_tag          = req_addr[ADDR_SIZE-1 -: TAG_W];
  assign req_index        = req_addr[2+OFF_W +: IDX_W];
  assign req_off          = req_addr[2 +: OFF_W];
  assign byte_bits_unused = ^req_addr[1:0];

  assign hit        = line_valid && (line_tag == req_tag);
  assign fill_we    = (state == FILL_WAIT) && !rom_busy;
  assign fill_last  = (count == OFF_W'(LINE_WORDS - 1));
  assign tag_we     = fill_we && fill_last;
  assign invalidate = (state == LOOKUP) && !hit;
  assign flush_now  = (state == IDLE) && (inst_cache_flush || flush_pending);

  always_comb begin
    hit_word = '0;
    for (int w = 0; w < LINE_WORDS; w++) begin
      if (req_off == OFF_W'(w)) hit_word = line[w*32 +: 32];
    end
  end

  instruction_cache_array #(
    .ADDR_SIZE (ADDR_SIZE),
    .LINE_WORDS(LINE_WORDS),
    .DEPTH     (DEPTH)
  ) u_array (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush_now),
    .invalidate(invalidate),
    .index     (req_index),
    .word      (count),
    .wdata     (rom_data),
    .we        (fill_we),
    .tag_we    (tag_we),
    .tag_in    (req_tag),
    .line      (line),
    .line_tag  (line_tag),
    .line_valid(line_valid)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      req_addr        <= '0;
      count           <= '0;
      flush_pending   <= 1'b0;
      inst_cache_busy <= 1'b0;
      inst_cache_data <= '0;
      rom_enable      <= 1'b0;
      rom_addr        <= '0;
    end else begin
      // A flush seen while busy is held until the FSM is back in IDLE.
      if (state != IDLE && inst_cache_flush) flush_pending <= 1'b1;
      case (state)
        IDLE: begin
          flush_pending <= 1'b0;
          if (inst_cache_enable) begin
            req_addr        <= inst_cache_addr;
            inst_cache_busy <= 1'b1;
            state           <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            inst_cache_data <= hit_word;
            inst_cache_busy <= 1'b0;
            state           <= DONE;
          end else begin
            count      <= '0;
            rom_enable <= 1'b1;
            rom_addr   <= {req_tag, req_index, {OFF_W{1'b0}}, 2'b00};
            state      <= FILL_REQ;
          end
        end
        FILL_REQ: begin
          if (rom_busy) state <= FILL_WAIT;
        end
        FILL_WAIT: begin
          if (!rom_busy) begin
            if (count == req_off) inst_cache_data <= rom_data;
            rom_enable <= 1'b0;
            if (fill_last) begin
              inst_cache_busy <= 1'b0;
              state           <= DONE;
            end else begin
              count <= count + 1'b1;
              state <= FILL_NEXT;
            end
          end
        end
        FILL_NEXT: begin
          rom_enable <= 1'b1;
          rom_addr   <= {req_tag, req_index, count, 2'b00};
          state      <= FILL_REQ;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
